tone_sequencer: RTL and testbench
=================================

// Module: tone_sequencer
// PURPOSE
//  Multi-song, multi-note square-wave tone player for game sound effects (win, lose, hop, ...).
//  A rising edge on trigger plays the song chosen by song_sel: NUM_NOTES notes in order.
//  Each note has its own half-period and duration, taken from parameter tables.
//  sound_out drives the board speaker/audio pin directly; busy/done report status to the game FSM.
// PARAMETERS
//  NUM_SONGS  2      number of selectable songs (>=1)
//  NUM_NOTES  3      notes per song (>=1)
//  HP_W       18     half-period counter width (clk cycles)
//  DUR_W      24     note-duration counter width (clk cycles)
//  HP_TBL     '0     packed [NUM_SONGS*NUM_NOTES*HP_W-1:0]; entry (s,n) at bit (s*NUM_NOTES+n)*HP_W; 0 = rest
//  DUR_TBL    '0     packed [NUM_SONGS*NUM_NOTES*DUR_W-1:0]; same indexing; 0 treated as 1
//  GAP_CYC    16     silent cycles between notes (used only with TONE_GAP_EN)
// PORTS
//  clk        in   1                    system clock (50 MHz)
//  reset      in   1                    asynchronous, active-high reset
//  trigger    in   1                    start request; acted on at rising edge only
//  song_sel   in   $clog2(NUM_SONGS)    song index, sampled on the trigger edge; >=NUM_SONGS plays song 0
//  abort      in   1                    stop playback immediately
//  sound_out  out  1                    square-wave audio output (registered)
//  busy       out  1                    high while a song is playing
//  done       out  1                    1-cycle pulse when the last note completes (not on abort)
//  note_idx   out  $clog2(NUM_NOTES)    index of note being played; 0 when idle
// BEHAVIOUR
//  Reset: state IDLE; sound_out=0, busy=0, done=0, note_idx=0; all counters and trig_q = 0.
//  Edge detect: trig_q <= trigger each cycle; start = trigger & ~trig_q.
//  States: IDLE -> PLAY on start. PLAY -> PLAY (next note) when dur_cnt==dur-1 and note_idx<NUM_NOTES-1.
//   PLAY -> IDLE on last note end: done=1 for that one cycle.
//  Latency: start seen at edge N -> busy=1, note_idx=0, sound_out=1 (or 0 if rest) from edge N+1.
//  Note timing: dur_cnt counts 0..dur-1; note occupies exactly dur cycles of sound_out.
//  Tone: hp_cnt counts 0..hp-1; sound_out toggles on wrap; each note starts with sound_out=1, hp_cnt=0.
//   hp==0 (rest): sound_out held 0 for the whole note.
//  Next note takes effect on the cycle immediately after the previous note's last cycle (no gap).
//  Total busy time = sum of song durations (each 0 taken as 1).
//  Retrigger: start while busy restarts at note 0 with newly sampled song_sel; no done pulse.
//  Abort: highest priority; next edge -> IDLE, sound_out=0, busy=0, no done. Abort+start same cycle -> abort wins.
//  Holding trigger high plays once; a new edge is required to replay.
//  Table lookup widths: index arithmetic in 32-bit ints; counters never exceed HP_W/DUR_W.
//  Reset asserted mid-song: all outputs to reset values asynchronously.
// CONFIGURATION
//  TONE_GAP_EN defined: state GAP inserted between notes (not after last).
//   GAP lasts GAP_CYC cycles, sound_out=0, busy=1, note_idx already = next note.
//   Abort/retrigger honoured in GAP.
//  TONE_GAP_EN undefined: no GAP state; notes back-to-back; GAP_CYC ignored.
// TESTING (NUM_SONGS=2, NUM_NOTES=3, HP_W=8, DUR_W=8; song0 HP={2,3,0}, DUR={8,6,4}; song1 HP={1,1,1}, DUR={2,2,2})
//  1. Reset, pulse trigger, song_sel=0 -> sound_out 11001100 111000 0000, busy 18 cycles, done 1 cycle after.
//  2. song_sel=1 -> sound_out 10 10 10; note_idx 0,0,1,1,2,2; busy 6 cycles; done pulse.
//  3. Abort at cycle 5 of song0 -> next cycle busy=0, sound_out=0, no done pulse.
//  4. Retrigger with song_sel=1 during song0 note1 -> restart at note_idx=0 with song1 pattern; single done at end.
//  5. Hold trigger high 40 cycles -> song plays once; reset asserted mid-note -> outputs 0 immediately.
//  6. TONE_GAP_EN, GAP_CYC=3, song1 -> 10 000 10 000 10; busy 12 cycles; done pulse.

Source files
------------

// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//   Multi-song, multi-note square-wave tone player for game sound effects.
//   A rising edge on trigger starts the song picked by song_sel; each of its
//   NUM_NOTES notes is played for its table duration as a square wave whose
//   half-period comes from a second table (half-period 0 = silent rest).
//
//   Optional feature macro: TONE_GAP_EN
//     defined   : GAP_CYC silent cycles are inserted between notes (not after
//                 the last one); note_idx already shows the upcoming note.
//     undefined : notes play back to back and GAP_CYC is ignored.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   trigger    in   start request, acted on at its rising edge only
//   song_sel   in   song index sampled with the trigger edge (out of range -> 0)
//   abort      in   stop playback at the next edge (wins over a start)
//   sound_out  out  registered square-wave audio output
//   busy       out  high while a song is playing
//   done       out  one-cycle pulse after the last note completes
//   note_idx   out  index of the note being played, 0 when idle
// -----------------------------------------------------------------------------
module tone_sequencer #(
   parameter int NUM_SONGS = 2,
   parameter int NUM_NOTES = 3,
   parameter int HP_W      = 18,
   parameter int DUR_W     = 24,
   parameter logic [NUM_SONGS*NUM_NOTES*HP_W-1:0]  HP_TBL  = '0,
   parameter logic [NUM_SONGS*NUM_NOTES*DUR_W-1:0] DUR_TBL = '0,
   parameter int GAP_CYC   = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic trigger,
   input  logic [((NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1)-1:0] song_sel,
   input  logic abort,
   output logic sound_out,
   output logic busy,
   output logic done,
   output logic [((NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1)-1:0] note_idx
);

   localparam int SW = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
   localparam int NW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
   localparam logic [NW-1:0] LAST_NOTE = NW'(NUM_NOTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_GAP
   } state_t;

   // Table lookups; index arithmetic is done in int so wide tables are safe.
   function automatic logic [HP_W-1:0] hp_at(input int s, input int n);
      hp_at = HP_TBL[(s * NUM_NOTES + n) * HP_W +: HP_W];
   endfunction

   // Returns the final dur_cnt value of a note; a zero duration plays 1 cycle.
   function automatic logic [DUR_W-1:0] dur_last_at(input int s, input int n);
      logic [DUR_W-1:0] d;
      d = DUR_TBL[(s * NUM_NOTES + n) * DUR_W +: DUR_W];
      dur_last_at = (d == '0) ? '0 : d - DUR_W'(1);
   endfunction

   state_t            state_reg, state_next;
   logic [SW-1:0]     song_reg, song_next;
   logic [NW-1:0]     note_reg, note_next;
   logic [DUR_W-1:0]  dur_cnt_reg, dur_cnt_next;
   logic [HP_W-1:0]   hp_cnt_reg, hp_cnt_next;
   logic              sound_reg, sound_next;
   logic              done_reg, done_next;
   logic              trig_q_reg;

   logic              start;
   logic [SW-1:0]     sel_eff;
   logic [HP_W-1:0]   cur_hp;
   logic [HP_W-1:0]   start_hp;
   logic [DUR_W-1:0]  cur_dur_last;
   logic              last_note;
   logic [NW-1:0]     next_note;

`ifdef TONE_GAP_EN
   localparam int GAP_LAST = (GAP_CYC > 1) ? GAP_CYC - 1 : 0;
   localparam int GW       = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
   logic [GW-1:0]     gap_cnt_reg, gap_cnt_next;
`else
   logic [HP_W-1:0]   next_hp;
   logic              gap_cyc_unused;
   assign gap_cyc_unused = ^GAP_CYC;
   assign next_hp        = hp_at(int'(song_reg), int'(next_note));
`endif

   assign start        = trigger & ~trig_q_reg;
   assign sel_eff      = (int'(song_sel) >= NUM_SONGS) ? '0 : song_sel;
   assign cur_hp       = hp_at(int'(song_reg), int'(note_reg));
   assign cur_dur_last = dur_last_at(int'(song_reg), int'(note_reg));
   assign start_hp     = hp_at(int'(sel_eff), 0);
   assign last_note    = (note_reg == LAST_NOTE);
   // Clamped so the lookup never indexes past the table on the last note.
   assign next_note    = last_note ? '0 : note_reg + NW'(1);

   always_comb begin
      state_next   = state_reg;
      song_next    = song_reg;
      note_next    = note_reg;
      dur_cnt_next = dur_cnt_reg;
      hp_cnt_next  = hp_cnt_reg;
      sound_next   = sound_reg;
      done_next    = 1'b0;
`ifdef TONE_GAP_EN
      gap_cnt_next = gap_cnt_reg;
`endif

      if (abort) begin
         state_next   = S_IDLE;
         note_next    = '0;
         dur_cnt_next = '0;
         hp_cnt_next  = '0;
         sound_next   = 1'b0;
      end else if (start) begin
         // Fresh start or retrigger: always restart from note 0.
         state_next   = S_PLAY;
         song_next    = sel_eff;
         note_next    = '0;
         dur_cnt_next = '0;
         hp_cnt_next  = '0;
         sound_next   = (start_hp != '0);
      end else begin
         case (state_reg)
            S_PLAY: begin
               if (dur_cnt_reg == cur_dur_last) begin
                  dur_cnt_next = '0;
                  hp_cnt_next  = '0;
                  if (last_note) begin
                     state_next = S_IDLE;
                     note_next  = '0;
                     sound_next = 1'b0;
                     done_next  = 1'b1;
                  end else begin
                     note_next = next_note;
`ifdef TONE_GAP_EN
                     state_next   = S_GAP;
                     gap_cnt_next = '0;
                     sound_next   = 1'b0;
`else
                     sound_next = (next_hp != '0);
`endif
                  end
               end else begin
                  dur_cnt_next = dur_cnt_reg + DUR_W'(1);
                  if (cur_hp == '0) begin
                     sound_next = 1'b0;
                  end else if (hp_cnt_reg == cur_hp - HP_W'(1)) begin
                     hp_cnt_next = '0;
                     sound_next  = ~sound_reg;
                  end else begin
                     hp_cnt_next = hp_cnt_reg + HP_W'(1);
                  end
               end
            end
`ifdef TONE_GAP_EN
            S_GAP: begin
               // note_reg already holds the upcoming note, so cur_hp is its tone.
               if (gap_cnt_reg == GW'(GAP_LAST)) begin
                  state_next  = S_PLAY;
                  hp_cnt_next = '0;
                  sound_next  = (cur_hp != '0);
               end else begin
                  gap_cnt_next = gap_cnt_reg + GW'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         song_reg    <= '0;
         note_reg    <= '0;
         dur_cnt_reg <= '0;
         hp_cnt_reg  <= '0;
         sound_reg   <= 1'b0;
         done_reg    <= 1'b0;
         trig_q_reg  <= 1'b0;
`ifdef TONE_GAP_EN
         gap_cnt_reg <= '0;
`endif
      end else begin
         state_reg   <= state_next;
         song_reg    <= song_next;
         note_reg    <= note_next;
         dur_cnt_reg <= dur_cnt_next;
         hp_cnt_reg  <= hp_cnt_next;
         sound_reg   <= sound_next;
         done_reg    <= done_next;
         trig_q_reg  <= trigger;
`ifdef TONE_GAP_EN
         gap_cnt_reg <= gap_cnt_next;
`endif
      end
   end

   assign sound_out = sound_reg;
   assign busy      = (state_reg != S_IDLE);
   assign done      = done_reg;
   assign note_idx  = note_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tone_sequencer
//   Self-checking bench for tone_sequencer with three songs (the third uses
//   zero durations and mixed rests; song_sel=3 must fall back to song 0).
//   The reference model expands a song into its per-cycle (sound, note) list
//   straight from the note tables and replays it from a queue.
// -----------------------------------------------------------------------------
module tb_tone_sequencer;

   localparam int GAP_C = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       trigger = 1'b0;
   logic [1:0] song_sel = 2'd0;
   logic       abort = 1'b0;
   logic       sound_out;
   logic       busy;
   logic       done;
   logic [1:0] note_idx;

   always #5 clk = ~clk;

   tone_sequencer #(
      .NUM_SONGS (3),
      .NUM_NOTES (3),
      .HP_W      (8),
      .DUR_W     (8),
      .HP_TBL    ({8'd1, 8'd0, 8'd5,  8'd1, 8'd1, 8'd1,  8'd0, 8'd3, 8'd2}),
      .DUR_TBL   ({8'd7, 8'd3, 8'd0,  8'd2, 8'd2, 8'd2,  8'd4, 8'd6, 8'd8}),
      .GAP_CYC   (GAP_C)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .trigger   (trigger),
      .song_sel  (song_sel),
      .abort     (abort),
      .sound_out (sound_out),
      .busy      (busy),
      .done      (done),
      .note_idx  (note_idx)
   );

   int hp_tab  [3][3] = '{'{2, 3, 0}, '{1, 1, 1}, '{5, 0, 1}};
   int dur_tab [3][3] = '{'{8, 6, 4}, '{2, 2, 2}, '{0, 3, 7}};

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model state: remaining cycles of the current song, {sound, note} each.
   logic [2:0] q[$];
   logic       exp_done  = 1'b0;
   logic       prev_trig = 1'b0;

   task automatic load_song(input int s);
      int hp;
      int d;
      logic snd;
      q.delete();
      for (int n = 0; n < 3; n++) begin
         hp = hp_tab[s][n];
         d  = (dur_tab[s][n] == 0) ? 1 : dur_tab[s][n];
         for (int k = 0; k < d; k++) begin
            snd = (hp != 0) && (((k / ((hp == 0) ? 1 : hp)) % 2) == 0);
            q.push_back({snd, 2'(n)});
         end
`ifdef TONE_GAP_EN
         if (n < 2)
            for (int g = 0; g < GAP_C; g++) q.push_back({1'b0, 2'(n + 1)});
`endif
      end
   endtask

   function automatic logic [4:0] expected();
      if (q.size() > 0) expected = {q[0][2], 1'b1, exp_done, q[0][1:0]};
      else              expected = {1'b0, 1'b0, exp_done, 2'b00};
   endfunction

   // Apply one cycle of inputs (from a negedge), advance the model at the
   // posedge and return at the following negedge for sampling.
   task automatic step(input logic t, input logic [1:0] s, input logic a);
      logic [2:0] tmp;
      trigger  = t;
      song_sel = s;
      abort    = a;
      @(posedge clk);
      if (a) begin
         q.delete();
         exp_done = 1'b0;
      end else if (t && !prev_trig) begin
         load_song((int'(s) >= 3) ? 0 : int'(s));
         exp_done = 1'b0;
      end else if (q.size() > 0) begin
         tmp = q.pop_front();
         exp_done = (q.size() == 0);
      end else begin
         exp_done = 1'b0;
      end
      prev_trig = t;
      cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if ({sound_out, busy, done, note_idx} !== 5'b0) begin
         errors++;
         $display("FAIL reset: snd/busy/done/note got %b required %b",
                  {sound_out, busy, done, note_idx}, 5'b0);
      end
      checks++;
      reset = 1'b0;
      repeat (2) begin
         step(1'b0, 2'd0, 1'b0);
         if ({sound_out, busy, done, note_idx} !== expected()) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: got %b required %b",
                     cyc, {sound_out, busy, done, note_idx}, expected());
         end
         checks++;
      end
      $display("test_reset complete at cycle %0d", cyc);
   endtask

   task automatic test_songs();
      for (int sel = 0; sel < 4; sel++) begin
         $display("play song_sel %0d at cycle %0d", sel, cyc);
         step(1'b1, 2'(sel), 1'b0);
         for (int i = 0; i < 32; i++) begin
            if ({sound_out, busy, done, note_idx} !== expected()) begin
               errors++;
               $display("FAIL song%0d cycle %0d: got %b required %b",
                        sel, cyc, {sound_out, busy, done, note_idx}, expected());
            end
            checks++;
            step(1'b0, 2'(sel), 1'b0);
         end
      end
   endtask

   task automatic test_hold_trigger();
      logic [1:0] sel;
      sel = 2'($urandom_range(0, 3));
      $display("hold trigger 40 cycles, song_sel %0d at cycle %0d", sel, cyc);
      for (int i = 0; i < 46; i++) begin
         step((i < 40), sel, 1'b0);
         if ({sound_out, busy, done, note_idx} !== expected()) begin
            errors++;
            $display("FAIL hold cycle %0d: got %b required %b",
                     cyc, {sound_out, busy, done, note_idx}, expected());
         end
         checks++;
      end
   endtask

   task automatic test_abort();
      int k;
      for (int r = 0; r < 4; r++) begin
         k = (r == 0) ? 4 : $urandom_range(0, 16);
         $display("abort after %0d cycles at cycle %0d", k + 1, cyc);
         step(1'b1, 2'd0, 1'b0);
         for (int i = 0; i < k; i++) step(1'b0, 2'd0, 1'b0);
         // Odd rounds pair the abort with a fresh trigger edge.
         step(r[0], 2'd1, 1'b1);
         for (int i = 0; i < 6; i++) begin
            if ({sound_out, busy, done, note_idx} !== expected()) begin
               errors++;
               $display("FAIL abort cycle %0d: got %b required %b",
                        cyc, {sound_out, busy, done, note_idx}, expected());
            end
            checks++;
            step(1'b0, 2'd0, 1'b0);
         end
      end
   endtask

   task automatic test_retrigger();
      int k;
      logic [1:0] sel;
      for (int r = 0; r < 3; r++) begin
         k   = $urandom_range(8, 13);
         sel = (r == 0) ? 2'd1 : 2'($urandom_range(0, 3));
         $display("retrigger song_sel %0d after %0d cycles at cycle %0d", sel, k, cyc);
         step(1'b1, 2'd0, 1'b0);
         for (int i = 0; i < k; i++) step(1'b0, 2'd0, 1'b0);
         step(1'b1, sel, 1'b0);
         for (int i = 0; i < 30; i++) begin
            if ({sound_out, busy, done, note_idx} !== expected()) begin
               errors++;
               $display("FAIL retrig cycle %0d: got %b required %b",
                        cyc, {sound_out, busy, done, note_idx}, expected());
            end
            checks++;
            step(1'b0, sel, 1'b0);
         end
      end
   endtask

   task automatic test_reset_mid();
      int k;
      k = $urandom_range(1, 10);
      $display("reset after %0d cycles of song 0 at cycle %0d", k, cyc);
      step(1'b1, 2'd0, 1'b0);
      for (int i = 0; i < k; i++) step(1'b0, 2'd0, 1'b0);
      trigger = 1'b0;
      reset   = 1'b1;
      #1;
      q.delete();
      exp_done  = 1'b0;
      prev_trig = 1'b0;
      if ({sound_out, busy, done, note_idx} !== 5'b0) begin
         errors++;
         $display("FAIL reset_async: got %b required %b",
                  {sound_out, busy, done, note_idx}, 5'b0);
      end
      checks++;
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 2'd1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if ({sound_out, busy, done, note_idx} !== expected()) begin
            errors++;
            $display("FAIL after_reset cycle %0d: got %b required %b",
                     cyc, {sound_out, busy, done, note_idx}, expected());
         end
         checks++;
         step(1'b0, 2'd1, 1'b0);
      end
   endtask

   task automatic test_random_mix();
      logic t;
      logic a;
      t = 1'b0;
      $display("random mix of 400 cycles from cycle %0d", cyc);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) t = ~t;
         a = ($urandom_range(0, 40) == 0);
         step(t, 2'($urandom_range(0, 3)), a);
         if ({sound_out, busy, done, note_idx} !== expected()) begin
            errors++;
            $display("FAIL random cycle %0d: got %b required %b",
                     cyc, {sound_out, busy, done, note_idx}, expected());
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_songs();
      test_hold_trigger();
      test_abort();
      test_retrigger();
      test_reset_mid();
      test_random_mix();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
